// File: rtl/ddr_wr_burst_master_if.sv
// ddr_wr_burst_master_if: AXI4 write-channel bundle between the burst master
// and the DDR controller slave port.
//   AW: m_awaddr, m_awlen, m_awvalid (master) / m_awready (slave)
//   W : m_wdata, m_wlast, m_wvalid (master) / m_wready (slave)
//   B : m_bready (master) / m_bvalid, m_bresp (slave)
// m_bresp is present only when DDR_WR_BRESP_ERR_EN is defined.
interface ddr_wr_burst_master_if #(
    parameter int unsigned c_DATA_WIDTH = 32,
    parameter int unsigned c_ADDR_WIDTH = 28
);
    logic [c_ADDR_WIDTH-1:0] m_awaddr;
    logic [7:0]              m_awlen;
    logic                    m_awvalid;
    logic                    m_awready;
    logic [c_DATA_WIDTH-1:0] m_wdata;
    logic                    m_wlast;
    logic                    m_wvalid;
    logic                    m_wready;
    logic                    m_bvalid;
    logic                    m_bready;
`ifdef DDR_WR_BRESP_ERR_EN
    logic [1:0]              m_bresp;
`endif

    modport master (
        output m_awaddr, m_awlen, m_awvalid, m_wdata, m_wlast, m_wvalid, m_bready,
`ifdef DDR_WR_BRESP_ERR_EN
        input  m_bresp,
`endif
        input  m_awready, m_wready, m_bvalid
    );

    modport slave (
        input  m_awaddr, m_awlen, m_awvalid, m_wdata, m_wlast, m_wvalid, m_bready,
`ifdef DDR_WR_BRESP_ERR_EN
        output m_bresp,
`endif
        output m_awready, m_wready, m_bvalid
    );
endinterface

// File: rtl/ddr_wr_burst_master.sv
// ddr_wr_burst_master: drains the frame write FIFO and issues fixed-length
// AXI4 write bursts to DDR, one frame of c_FRAME_BURSTS bursts per frame_start.
//
// Ports:
//   rd_clk, rd_rst        FIFO read clock, asynchronous active-high reset
//   frame_start           pulse: start a frame at c_BASE_ADDR (ignored when busy)
//   fifo_rd_en            FIFO read enable (data returns one cycle later)
//   fifo_rd_data          FIFO read data
//   fifo_rd_empty         FIFO empty
//   fifo_rd_water_level   words available in the FIFO
//   axi                   AXI4 write channels (master modport)
//   busy                  frame in progress
//   frame_done            pulse after the final B response of a frame
//   err_cnt, err_flag     (DDR_WR_BRESP_ERR_EN only) saturating count of
//                         non-OKAY responses and sticky error flag
//
// Optional feature macro: DDR_WR_BRESP_ERR_EN.
module ddr_wr_burst_master #(
    parameter int unsigned c_DATA_WIDTH   = 32,
    parameter int unsigned c_LEVEL_WIDTH  = 11,
    parameter int unsigned c_ADDR_WIDTH   = 28,
    parameter int unsigned c_BURST_LEN    = 16,
    parameter int unsigned c_BASE_ADDR    = 0,
    parameter int unsigned c_FRAME_BURSTS = 64
) (
    input  logic                     rd_clk,
    input  logic                     rd_rst,
    input  logic                     frame_start,
    output logic                     fifo_rd_en,
    input  logic [c_DATA_WIDTH-1:0]  fifo_rd_data,
    input  logic                     fifo_rd_empty,
    input  logic [c_LEVEL_WIDTH-1:0] fifo_rd_water_level,
    ddr_wr_burst_master_if.master    axi,
    output logic                     busy,
    output logic                     frame_done
`ifdef DDR_WR_BRESP_ERR_EN
    ,
    output logic [15:0]              err_cnt,
    output logic                     err_flag
`endif
);

    localparam int unsigned CNT_W           = $clog2(c_BURST_LEN + 1);
    localparam int unsigned IDX_W           = (c_FRAME_BURSTS > 1) ? $clog2(c_FRAME_BURSTS) : 1;
    localparam int unsigned BYTES_PER_BURST = c_BURST_LEN * (c_DATA_WIDTH / 8);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEVEL,
        S_ADDR,
        S_DATA,
        S_RESP
    } state_t;

    state_t                  state_q, state_d;
    logic [CNT_W-1:0]        reads_q;
    logic [CNT_W-1:0]        beats_q;
    logic [IDX_W-1:0]        burst_idx_q;
    logic [c_DATA_WIDTH-1:0] skid_data_q [2];
    logic                    skid_wr_q;
    logic                    skid_rd_q;
    logic [1:0]              skid_cnt_q;
    logic                    rd_pending_q;
    logic [c_ADDR_WIDTH-1:0] awaddr_q;
    logic                    awvalid_q;
    logic                    bready_q;
    logic                    busy_q;
    logic                    frame_done_q;

    logic       level_ok;
    logic       last_burst;
    logic       aw_fire;
    logic       w_fire;
    logic       b_fire;
    logic [1:0] skid_occ;

    assign level_ok   = fifo_rd_water_level >= c_LEVEL_WIDTH'(c_BURST_LEN);
    assign last_burst = burst_idx_q == IDX_W'(c_FRAME_BURSTS - 1);
    assign aw_fire    = awvalid_q && axi.m_awready;
    assign w_fire     = axi.m_wvalid && axi.m_wready;
    assign b_fire     = bready_q && axi.m_bvalid;

    // Occupancy the skid will have once this cycle's pop and in-flight read
    // settle; counting the pop keeps the 2-entry buffer at 1 beat/clk.
    assign skid_occ = skid_cnt_q + {1'b0, rd_pending_q} - {1'b0, w_fire};

    assign fifo_rd_en = (state_q == S_DATA) && (reads_q < CNT_W'(c_BURST_LEN))
                        && !fifo_rd_empty && (skid_occ < 2'd2);

    // Head of the skid buffer drives W; it only moves on a handshake.
    assign axi.m_wvalid  = skid_cnt_q != 2'd0;
    assign axi.m_wdata   = skid_data_q[skid_rd_q];
    assign axi.m_wlast   = axi.m_wvalid && (beats_q == CNT_W'(c_BURST_LEN - 1));
    assign axi.m_awaddr  = awaddr_q;
    assign axi.m_awlen   = 8'(c_BURST_LEN - 1);
    assign axi.m_awvalid = awvalid_q;
    assign axi.m_bready  = bready_q;
    assign busy          = busy_q;
    assign frame_done    = frame_done_q;

    // State register
    always_ff @(posedge rd_clk or posedge rd_rst) begin
        if (rd_rst) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:  if (frame_start) state_d = S_LEVEL;
            S_LEVEL: if (level_ok) state_d = S_ADDR;
            S_ADDR:  if (aw_fire) state_d = S_DATA;
            S_DATA:  if (w_fire && axi.m_wlast) state_d = S_RESP;
            S_RESP:  if (b_fire) state_d = last_burst ? S_IDLE : S_LEVEL;
            default: state_d = S_IDLE;
        endcase
    end

    // Registered control outputs, decoded from the next state
    always_ff @(posedge rd_clk or posedge rd_rst) begin
        if (rd_rst) begin
            awvalid_q    <= 1'b0;
            bready_q     <= 1'b0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
            awaddr_q     <= '0;
        end else begin
            awvalid_q    <= state_d == S_ADDR;
            bready_q     <= state_d == S_RESP;
            busy_q       <= state_d != S_IDLE;
            frame_done_q <= b_fire && last_burst;
            if (state_q == S_LEVEL && level_ok) begin
                awaddr_q <= c_ADDR_WIDTH'(c_BASE_ADDR)
                          + c_ADDR_WIDTH'(burst_idx_q) * c_ADDR_WIDTH'(BYTES_PER_BURST);
            end
        end
    end

    // Per-burst read/beat counters and frame burst index
    always_ff @(posedge rd_clk or posedge rd_rst) begin
        if (rd_rst) begin
            reads_q     <= '0;
            beats_q     <= '0;
            burst_idx_q <= '0;
        end else begin
            if (aw_fire) begin
                reads_q <= '0;
                beats_q <= '0;
            end else begin
                if (fifo_rd_en) reads_q <= reads_q + CNT_W'(1);
                if (w_fire)     beats_q <= beats_q + CNT_W'(1);
            end
            if (b_fire) burst_idx_q <= last_burst ? '0 : burst_idx_q + IDX_W'(1);
        end
    end

    // Two-entry skid buffer absorbing the one-cycle FIFO read latency
    always_ff @(posedge rd_clk or posedge rd_rst) begin
        if (rd_rst) begin
            for (int i = 0; i < 2; i++) skid_data_q[i] <= '0;
            skid_wr_q    <= 1'b0;
            skid_rd_q    <= 1'b0;
            skid_cnt_q   <= '0;
            rd_pending_q <= 1'b0;
        end else begin
            rd_pending_q <= fifo_rd_en;
            if (rd_pending_q) begin
                skid_data_q[skid_wr_q] <= fifo_rd_data;
                skid_wr_q              <= ~skid_wr_q;
            end
            if (w_fire) skid_rd_q <= ~skid_rd_q;
            skid_cnt_q <= skid_cnt_q + {1'b0, rd_pending_q} - {1'b0, w_fire};
        end
    end

`ifdef DDR_WR_BRESP_ERR_EN
    // Saturating error counter and sticky flag for non-OKAY responses
    always_ff @(posedge rd_clk or posedge rd_rst) begin
        if (rd_rst) begin
            err_cnt  <= '0;
            err_flag <= 1'b0;
        end else if (b_fire && axi.m_bresp != 2'b00) begin
            if (err_cnt != 16'hFFFF) err_cnt <= err_cnt + 16'd1;
            err_flag <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_ddr_wr_burst_master.sv
`timescale 1ns/1ps
// Bench for ddr_wr_burst_master: a queue-based FIFO model feeds random words;
// the expected W stream is the FIFO push order, expected addresses are
// burst_number * bytes_per_burst, and per-burst/frame counts are tallied.
module tb_ddr_wr_burst_master;
    localparam int unsigned DW = 32;
    localparam int unsigned LW = 11;
    localparam int unsigned AW = 28;
    localparam int unsigned BL = 16;
    localparam int unsigned FB = 4;
    localparam int unsigned BYTES_PER_BURST = BL * DW / 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          frame_start;
    logic          fifo_rd_en;
    logic [DW-1:0] fifo_rd_data;
    logic          fifo_rd_empty;
    logic [LW-1:0] fifo_rd_water_level;
    logic          busy;
    logic          frame_done;
`ifdef DDR_WR_BRESP_ERR_EN
    logic [15:0]   err_cnt;
    logic          err_flag;
`endif

    ddr_wr_burst_master_if #(.c_DATA_WIDTH(DW), .c_ADDR_WIDTH(AW)) axi ();

    ddr_wr_burst_master #(
        .c_DATA_WIDTH(DW), .c_LEVEL_WIDTH(LW), .c_ADDR_WIDTH(AW),
        .c_BURST_LEN(BL), .c_BASE_ADDR(0), .c_FRAME_BURSTS(FB)
    ) dut (
        .rd_clk(clk), .rd_rst(rst), .frame_start(frame_start),
        .fifo_rd_en(fifo_rd_en), .fifo_rd_data(fifo_rd_data),
        .fifo_rd_empty(fifo_rd_empty), .fifo_rd_water_level(fifo_rd_water_level),
        .axi(axi), .busy(busy), .frame_done(frame_done)
`ifdef DDR_WR_BRESP_ERR_EN
        , .err_cnt(err_cnt), .err_flag(err_flag)
`endif
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    logic [DW-1:0] fifo_q[$];
    logic [DW-1:0] exp_q[$];
    int  to_push = 0;
    int  level_override = -1;
    int  wready_mode = 0;
    int  aw_delay = 0;
    int  aw_wait = 0;
    bit  fs_req = 0;
    bit  bvalid_rand = 0;
    bit  err_inject = 0;
    bit  stream_chk = 0;
    bit  have_rd_word = 0;
    logic [DW-1:0] rd_word;
    int  burst_cnt, beat, reads, outstanding, resp_cnt, done_cnt;
    int  err_exp = 0;
    bit  aw_done, aw_pending, w_held;
    logic [AW-1:0] aw_first;
    logic [DW-1:0] held_data;
    logic          held_last;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        burst_cnt = 0; beat = 0; reads = 0; outstanding = 0;
        resp_cnt = 0; done_cnt = 0; aw_wait = 0;
        aw_done = 0; aw_pending = 0; w_held = 0; have_rd_word = 0;
    endtask

    task automatic load(input int n, input int trickle);
        logic [DW-1:0] w;
        fifo_q.delete();
        exp_q.delete();
        for (int i = 0; i < n; i++) begin
            w = $urandom;
            fifo_q.push_back(w);
            exp_q.push_back(w);
        end
        to_push = trickle;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_rd_en"},   fifo_rd_en, 0);
        check({tag, "_awaddr"},  axi.m_awaddr, 0);
        check({tag, "_awvalid"}, axi.m_awvalid, 0);
        check({tag, "_awlen"},   axi.m_awlen, BL - 1);
        check({tag, "_wdata"},   axi.m_wdata, 0);
        check({tag, "_wlast"},   axi.m_wlast, 0);
        check({tag, "_wvalid"},  axi.m_wvalid, 0);
        check({tag, "_bready"},  axi.m_bready, 0);
        check({tag, "_busy"},    busy, 0);
        check({tag, "_done"},    frame_done, 0);
`ifdef DDR_WR_BRESP_ERR_EN
        check({tag, "_err_cnt"},  err_cnt, 0);
        check({tag, "_err_flag"}, err_flag, 0);
`endif
    endtask

    // Observe one cycle's outputs (sampled just after the falling edge).
    task automatic monitor();
        if (aw_pending) begin
            check("aw_hold_valid", axi.m_awvalid, 1);
            check("aw_hold_addr", axi.m_awaddr, aw_first);
        end
        if (axi.m_awvalid && axi.m_awready) begin
            check("awaddr", axi.m_awaddr, 64'(burst_cnt * BYTES_PER_BURST));
            check("awlen", axi.m_awlen, BL - 1);
            check("aw_one_outstanding", aw_done, 0);
            check("aw_wait_len", aw_wait, aw_delay);
            aw_done = 1; beat = 0; reads = 0; aw_wait = 0; aw_pending = 0;
        end else if (axi.m_awvalid) begin
            aw_pending = 1;
            aw_first = axi.m_awaddr;
            aw_wait++;
        end else begin
            aw_pending = 0;
        end

        if (fifo_rd_en) begin
            check("rd_while_empty", fifo_rd_empty, 0);
            check("rd_before_aw", aw_done, 1);
            reads++;
            check("rd_per_burst_max", reads <= BL, 1);
            if (fifo_q.size() > 0) begin
                rd_word = fifo_q.pop_front();
                have_rd_word = 1;
            end
            outstanding++;
        end

        if (w_held) begin
            check("w_hold_valid", axi.m_wvalid, 1);
            check("w_hold_data", axi.m_wdata, held_data);
            check("w_hold_last", axi.m_wlast, held_last);
        end
        if (stream_chk && aw_done && beat > 0) check("throughput", axi.m_wvalid, 1);
        if (axi.m_wvalid) begin
            check("w_before_aw", aw_done, 1);
            if (axi.m_wready) begin
                if (exp_q.size() == 0) check("w_extra_beat", 1, 0);
                else check("wdata", axi.m_wdata, exp_q.pop_front());
                check("wlast", axi.m_wlast, beat == BL - 1);
                beat++;
                outstanding--;
                if (axi.m_wlast) begin
                    check("rd_per_burst", reads, BL);
                    aw_done = 0;
                    burst_cnt++;
                end
            end
        end
        w_held = axi.m_wvalid && !axi.m_wready;
        held_data = axi.m_wdata;
        held_last = axi.m_wlast;
        if (aw_done) check("skid_depth", outstanding <= 2, 1);

        if (axi.m_bready && axi.m_bvalid) begin
            check("b_after_wlast", !aw_done && burst_cnt == resp_cnt + 1, 1);
`ifdef DDR_WR_BRESP_ERR_EN
            if (axi.m_bresp != 2'b00 && err_exp < 65535) err_exp++;
`endif
            resp_cnt++;
        end
        if (frame_done) begin
            done_cnt++;
            check("busy_with_done", busy, 0);
            check("done_after_resp", resp_cnt, FB);
        end
    endtask

    // Drive inputs on the falling edge, then observe.
    task automatic step();
        logic [DW-1:0] w;
        @(negedge clk);
        frame_start = fs_req;
        fs_req = 0;
        if (have_rd_word) begin
            fifo_rd_data = rd_word;
            have_rd_word = 0;
        end
        if (to_push > 0 && $urandom_range(0, 1) == 1) begin
            w = $urandom;
            fifo_q.push_back(w);
            exp_q.push_back(w);
            to_push--;
        end
        fifo_rd_empty = fifo_q.size() == 0;
        fifo_rd_water_level = (level_override >= 0) ? LW'(level_override) : LW'(fifo_q.size());
        case (wready_mode)
            0:       axi.m_wready = 1'b1;
            1:       axi.m_wready = !axi.m_wready;
            default: axi.m_wready = 1'($urandom_range(0, 1));
        endcase
        axi.m_awready = aw_wait >= aw_delay;
        axi.m_bvalid  = bvalid_rand ? 1'($urandom_range(0, 1)) : 1'b1;
`ifdef DDR_WR_BRESP_ERR_EN
        axi.m_bresp = (err_inject && (resp_cnt == 1 || resp_cnt == 3)) ? 2'b10 : 2'b00;
`endif
        #1;
        monitor();
    endtask

    task automatic run_frame(input bit start, input int budget, input int fs_at_burst);
        int n = 0;
        if (start) fs_req = 1;
        while (done_cnt == 0 && n < budget) begin
            step();
            n++;
            if (fs_at_burst >= 0 && burst_cnt == fs_at_burst && beat == 3) fs_req = 1;
        end
        check("frame_timeout", done_cnt != 0, 1);
    endtask

    task automatic finish_frame(input string tag);
        repeat (4) step();
        check({tag, "_done_once"}, done_cnt, 1);
        check({tag, "_bursts"}, burst_cnt, FB);
        check({tag, "_resps"}, resp_cnt, FB);
        check({tag, "_all_drained"}, exp_q.size(), 0);
        check({tag, "_idle"}, busy, 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1;
        err_exp = 0;
        #1;
        check_all_zero("reset");
        @(negedge clk);
        rst = 0;
        model_clear();
    endtask

    initial begin
        int n;
        rst = 1; frame_start = 0; fifo_rd_data = '0; fifo_rd_empty = 1;
        fifo_rd_water_level = '0;
        axi.m_awready = 0; axi.m_wready = 0; axi.m_bvalid = 0;
`ifdef DDR_WR_BRESP_ERR_EN
        axi.m_bresp = 2'b00;
`endif
        repeat (3) @(negedge clk);
        #1;
        check_all_zero("por");
        @(negedge clk);
        rst = 0;

        // Full-speed frame from a preloaded FIFO
        model_clear(); load(64, 0); stream_chk = 1;
        run_frame(1, 1000, -1); finish_frame("fast");
        stream_chk = 0;

        // Water level one short of a burst stalls the frame
        model_clear(); load(64, 0); level_override = 15; fs_req = 1;
        repeat (12) begin
            step();
            check("lvl15_awvalid", axi.m_awvalid, 0);
            check("lvl15_rd_en", fifo_rd_en, 0);
        end
        level_override = 16;
        step();
        step();
        check("lvl16_awvalid", axi.m_awvalid, 1);
        level_override = -1;
        run_frame(0, 1000, -1); finish_frame("level");

        // W back-pressure toggling every cycle
        wready_mode = 1;
        model_clear(); load(64, 0);
        run_frame(1, 2000, -1); finish_frame("toggle");
        wready_mode = 0;

        // AW acceptance delayed by 5 cycles
        aw_delay = 5;
        model_clear(); load(64, 0);
        run_frame(1, 2000, -1); finish_frame("awdelay");
        aw_delay = 0;

        // frame_start during burst 2 is ignored
        model_clear(); load(64, 0);
        run_frame(1, 1000, 2); finish_frame("fs_busy");

        // Random back-pressure, random B timing, trickle-filled FIFO
        wready_mode = 2; bvalid_rand = 1;
        model_clear(); load(20, 44);
        run_frame(1, 5000, -1); finish_frame("random");
        wready_mode = 0; bvalid_rand = 0;

        // Reset in the middle of burst 0, beat 7, then a clean frame
        model_clear(); load(64, 0); fs_req = 1;
        n = 0;
        while (!(aw_done && burst_cnt == 0 && beat == 7) && n < 200) begin
            step();
            n++;
        end
        check("reach_beat7", beat, 7);
        rst = 1;
        err_exp = 0;
        #1;
        check_all_zero("rst_mid");
        @(negedge clk);
        rst = 0;
        model_clear(); load(64, 0);
        run_frame(1, 1000, -1); finish_frame("after_rst");

`ifdef DDR_WR_BRESP_ERR_EN
        // Error responses on bursts 1 and 3
        do_reset();
        err_inject = 1;
        load(64, 0);
        run_frame(1, 1000, -1); finish_frame("bresp");
        err_inject = 0;
        check("err_cnt", err_cnt, 64'(err_exp));
        check("err_cnt_two", err_cnt, 2);
        check("err_flag", err_flag, 1);
        do_reset();
`else
        do_reset();
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
